ps2_host_tx: RTL

PS/2 host-to-device transmitter. It is the sending counterpart of the keyboard receiver, and it sits beside that receiver on the same PS2_clk / PS2_data pair. It sends one command byte to the keyboard, for example 0xED set-LEDs or 0xFF reset, using the standard request-to-send sequence. It then reports whether the device acknowledged the byte. While it is active it asks the receiver to ignore bus traffic, and it releases the open-drain lines whenever it is idle or in reset.

---
 rtl/ps2_host_tx_if.sv | 20 ++
 rtl/ps2_host_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Command/status bundle between a PS/2 command source and the host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;
  logic       ack_ok;
  logic       error;
  logic       rx_inhibit;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, done, ack_ok, error, rx_inhibit
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, done, ack_ok, error, rx_inhibit
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 8 data bits,
// odd parity, stop, then samples the device ack. Open-drain lines driven via oe.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned FILTER_LEN     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             rst,
  ps2_host_tx_if.slave     bus,
  input  logic             PS2_clk_i,
  input  logic             PS2_data_i,
  output logic             PS2_clk_oe,
  output logic             PS2_data_oe
);

  localparam int unsigned InhW  = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StAck,
    StWaitIdle
  } state_e;

  state_e state_q, state_d;

  logic             clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic             clk_filt_q, fall_q;
  logic [FiltW-1:0] filt_cnt_q;

  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [InhW-1:0]  inh_cnt_q, inh_cnt_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;

  logic clk_oe_q, clk_oe_d;
  logic data_oe_q, data_oe_d;
  logic tx_ready_q, tx_ready_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic ack_ok_q, ack_ok_d;
  logic rx_inhibit_q, rx_inhibit_d;

  // Synchronize both lines; debounce the clock and flag filtered falling edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_meta_q  <= PS2_clk_i;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= PS2_data_i;
      data_sync_q <= data_meta_q;
      fall_q      <= 1'b0;
      if (clk_sync_q == clk_filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        // FILTER_LEN consecutive differing samples: accept the new level.
        clk_filt_q <= clk_sync_q;
        filt_cnt_q <= '0;
        fall_q     <= ~clk_sync_q;
      end else begin
        filt_cnt_q <= filt_cnt_q + FiltW'(1);
      end
    end
  end

  // Next-state, datapath and next-output decisions.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    bitcnt_d  = bitcnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_oe_d  = 1'b0;
    data_oe_d = data_oe_q;
    ack_ok_d  = ack_ok_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        data_oe_d = 1'b0;
        if (bus.tx_valid && tx_ready_q) begin
          shreg_d   = bus.tx_data;
          par_d     = ~^bus.tx_data;
          inh_cnt_d = '0;
          state_d   = StInhibit;
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES == 1);
        end
      end

      StInhibit: begin
        inh_cnt_d = inh_cnt_q + InhW'(1);
        if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
          // Release the clock; data stays low as the start bit.
          state_d   = StReq;
          bitcnt_d  = '0;
          to_cnt_d  = '0;
          data_oe_d = 1'b1;
        end else begin
          clk_oe_d  = 1'b1;
          data_oe_d = (inh_cnt_d == InhW'(INHIBIT_CYCLES - 1));
        end
      end

      StReq, StAck, StWaitIdle: begin
        to_cnt_d = to_cnt_q + ToW'(1);
        if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StIdle;
          data_oe_d = 1'b0;
          ack_ok_d  = 1'b0;
          error_d   = 1'b1;
        end else if (state_q == StReq) begin
          if (fall_q) begin
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_d <= 4'd8) begin
              data_oe_d = ~shreg_q[bitcnt_q[2:0]];
            end else if (bitcnt_d == 4'd9) begin
              data_oe_d = ~par_q;
            end else begin
              data_oe_d = 1'b0;
              state_d   = StAck;
            end
          end
        end else if (state_q == StAck) begin
          if (fall_q) begin
            bitcnt_d = bitcnt_q + 4'd1;
            ack_ok_d = ~data_sync_q;
            state_d  = StWaitIdle;
          end
        end else begin
          if (clk_sync_q && data_sync_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d   = StIdle;
        data_oe_d = 1'b0;
      end
    endcase

    // Ready is withheld during the done/error cycle so it returns the cycle after.
    tx_ready_d   = (state_d == StIdle) && !done_d && !error_d;
    rx_inhibit_d = (state_d != StIdle);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      bitcnt_q     <= '0;
      inh_cnt_q    <= '0;
      to_cnt_q     <= '0;
      clk_oe_q     <= 1'b0;
      data_oe_q    <= 1'b0;
      tx_ready_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      ack_ok_q     <= 1'b0;
      rx_inhibit_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      bitcnt_q     <= bitcnt_d;
      inh_cnt_q    <= inh_cnt_d;
      to_cnt_q     <= to_cnt_d;
      clk_oe_q     <= clk_oe_d;
      data_oe_q    <= data_oe_d;
      tx_ready_q   <= tx_ready_d;
      done_q       <= done_d;
      error_q      <= error_d;
      ack_ok_q     <= ack_ok_d;
      rx_inhibit_q <= rx_inhibit_d;
    end
  end

  assign PS2_clk_oe     = clk_oe_q;
  assign PS2_data_oe    = data_oe_q;
  assign bus.tx_ready   = tx_ready_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.ack_ok     = ack_ok_q;
  assign bus.rx_inhibit = rx_inhibit_q;

endmodule
